// File: rtl/data_cache_pkg.sv
// Shared constants, types and helpers for the direct-mapped data cache.
// Line layout: [63:0] block data, [64] VALID, [65] DIRTY, [76:66] tag.
package data_cache_pkg;

    localparam int WORD_SIZE  = 16;
    localparam int BLOCK_SIZE = 4;
    localparam int BLOCK_W    = WORD_SIZE * BLOCK_SIZE;
    localparam int LINE_SIZE  = 77;
    localparam int VALID      = 64;
    localparam int DIRTY      = 65;
    localparam int TAG_LSB    = 66;
    localparam int TAG_MSB    = 76;
    localparam int TAG_W      = TAG_MSB - TAG_LSB + 1;
    localparam int NUM_LINES  = 8;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 2;
    localparam int ADDR_W     = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } cache_state_t;

    typedef logic [LINE_SIZE-1:0] line_t;
    typedef logic [BLOCK_W-1:0]   block_t;

    // Address field extraction: tag = [15:5], index = [4:2], offset = [1:0].
    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[15:5];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[4:2];
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
        return a[1:0];
    endfunction

    // Pick word 'off' out of a block; word k lives in bits [16k+15:16k].
    function automatic logic [WORD_SIZE-1:0] get_word(input block_t blk,
                                                      input logic [OFFSET_W-1:0] off);
        logic [WORD_SIZE-1:0] w;
        case (off)
            2'd0:    w = blk[15:0];
            2'd1:    w = blk[31:16];
            2'd2:    w = blk[47:32];
            default: w = blk[63:48];
        endcase
        return w;
    endfunction

    // Replace word 'off' in a block with 'w', leaving the other words intact.
    function automatic block_t put_word(input block_t blk,
                                        input logic [OFFSET_W-1:0] off,
                                        input logic [WORD_SIZE-1:0] w);
        block_t res;
        res = blk;
        case (off)
            2'd0:    res[15:0]  = w;
            2'd1:    res[31:16] = w;
            2'd2:    res[47:32] = w;
            default: res[63:48] = w;
        endcase
        return res;
    endfunction

    // Assemble a full line from its fields.
    function automatic line_t make_line(input logic [TAG_W-1:0] tag,
                                        input logic dirty,
                                        input logic valid,
                                        input block_t blk);
        return {tag, dirty, valid, blk};
    endfunction

endpackage

// File: rtl/data_cache_array.sv
// Line storage for the data cache: 8 lines x 77 bits, one combinational read
// port and one synchronous write port. Only VALID/DIRTY are cleared by reset;
// data and tag contents are don't-care until a line is installed.
module cache_array
    import data_cache_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [INDEX_W-1:0] rd_index,
    output line_t              rd_line,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  line_t              wr_line
);

    block_t             data_mem [NUM_LINES];
    logic [TAG_W-1:0]   tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_reg;
    logic [NUM_LINES-1:0] dirty_reg;
    logic [NUM_LINES-1:0] line_we;

    // Per-line write enable decode.
    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line_we
            assign line_we[gi] = wr_en && (wr_index == INDEX_W'(gi));
        end
    endgenerate

    // Data and tag payload: plain storage, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_index] <= wr_line[BLOCK_W-1:0];
            tag_mem[wr_index]  <= wr_line[TAG_MSB:TAG_LSB];
        end
    end

    // Status bits: cleared asynchronously so every line is invalid after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_reg <= '0;
            dirty_reg <= '0;
        end else begin
            for (int i = 0; i < NUM_LINES; i++) begin
                if (line_we[i]) begin
                    valid_reg[i] <= wr_line[VALID];
                    dirty_reg[i] <= wr_line[DIRTY];
                end
            end
        end
    end

    // An invalid line never reports itself dirty, so a cold victim is never
    // written back.
    assign rd_line = {tag_mem[rd_index],
                      dirty_reg[rd_index] & valid_reg[rd_index],
                      valid_reg[rd_index],
                      data_mem[rd_index]};

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines of 4 x 16-bit
// words. Hits complete on the sampling edge; misses hand the victim line to
// memory on evict, fetch the block via readM/finish and install it.
module data_cache
    import data_cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    input  logic [ADDR_W-1:0]    cpu_address,
    input  logic [WORD_SIZE-1:0] cpu_write_data,
    output logic [WORD_SIZE-1:0] cpu_read_data,
    output logic                 cpu_ready,
    output logic                 readM,
    output logic [ADDR_W-1:0]    address,
    output logic [LINE_SIZE-1:0] evict,
    input  logic [BLOCK_W-1:0]   data,
    input  logic                 finish,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
);

    cache_state_t         state_reg, state_next;
    logic [ADDR_W-1:0]    addr_reg, addr_next;
    logic [WORD_SIZE-1:0] wdata_reg, wdata_next;
    logic                 is_write_reg, is_write_next;
    logic                 ready_reg, ready_next;
    logic [WORD_SIZE-1:0] read_data_reg, read_data_next;
    logic [15:0]          hit_count_reg, miss_count_reg;
    logic                 hit_inc, miss_inc;

    logic [ADDR_W-1:0]    lookup_addr;
    logic [INDEX_W-1:0]   line_index;
    line_t                rd_line;
    line_t                wr_line;
    logic                 arr_we;
    logic                 cpu_req;
    logic                 tag_hit;
    block_t               fill_block;

    // In IDLE the live CPU address is looked up so a hit finishes on the
    // sampling edge; during a miss the latched address owns the array.
    assign lookup_addr = (state_reg == S_IDLE) ? cpu_address : addr_reg;
    assign line_index  = addr_index(lookup_addr);
    assign cpu_req     = cpu_read | cpu_write;
    assign tag_hit     = rd_line[VALID] && (rd_line[TAG_MSB:TAG_LSB] == addr_tag(lookup_addr));

    // Block to install on refill: store data is merged into the fetched block.
    assign fill_block = is_write_reg ? put_word(data, addr_offset(addr_reg), wdata_reg) : data;

    cache_array u_array (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_index (line_index),
        .rd_line  (rd_line),
        .wr_en    (arr_we),
        .wr_index (line_index),
        .wr_line  (wr_line)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state, array write and completion decode.
    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        is_write_next  = is_write_reg;
        ready_next     = 1'b0;
        read_data_next = read_data_reg;
        hit_inc        = 1'b0;
        miss_inc       = 1'b0;
        arr_we         = 1'b0;
        wr_line        = rd_line;

        case (state_reg)
            S_IDLE: begin
                if (cpu_req) begin
                    addr_next     = cpu_address;
                    wdata_next    = cpu_write_data;
                    // A simultaneous read and write is treated as a write.
                    is_write_next = cpu_write;
                    if (tag_hit) begin
                        ready_next = 1'b1;
                        hit_inc    = 1'b1;
                        if (cpu_write) begin
                            arr_we  = 1'b1;
                            wr_line = make_line(rd_line[TAG_MSB:TAG_LSB], 1'b1, 1'b1,
                                                put_word(rd_line[BLOCK_W-1:0],
                                                         addr_offset(cpu_address),
                                                         cpu_write_data));
                        end else begin
                            read_data_next = get_word(rd_line[BLOCK_W-1:0],
                                                      addr_offset(cpu_address));
                        end
                    end else begin
                        state_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // Wait for memory to acknowledge by dropping finish.
                if (!finish) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (finish) begin
                    arr_we     = 1'b1;
                    wr_line    = make_line(addr_tag(addr_reg), is_write_reg, 1'b1, fill_block);
                    ready_next = 1'b1;
                    miss_inc   = 1'b1;
                    state_next = S_IDLE;
                    if (!is_write_reg) begin
                        read_data_next = get_word(data, addr_offset(addr_reg));
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Latched request and registered CPU-side outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_reg      <= '0;
            wdata_reg     <= '0;
            is_write_reg  <= 1'b0;
            ready_reg     <= 1'b0;
            read_data_reg <= '0;
        end else begin
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            is_write_reg  <= is_write_next;
            ready_reg     <= ready_next;
            read_data_reg <= read_data_next;
        end
    end

    // Hit and miss counters, wrapping modulo 2^16.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            if (hit_inc) begin
                hit_count_reg <= hit_count_reg + 16'd1;
            end
            if (miss_inc) begin
                miss_count_reg <= miss_count_reg + 16'd1;
            end
        end
    end

    // readM drops combinationally as soon as finish returns high in WAIT, so
    // memory never sees a second request for the same miss.
    assign readM         = (state_reg == S_REQ) || ((state_reg == S_WAIT) && !finish);
    assign evict         = (state_reg == S_REQ) ? rd_line : '0;
    assign address       = addr_reg;
    assign cpu_ready     = ready_reg;
    assign cpu_read_data = read_data_reg;
    assign hit_count     = hit_count_reg;
    assign miss_count    = miss_count_reg;

endmodule

// File: tb/tb_data_cache.sv
// Directed testbench for data_cache with a small behavioural memory that
// accepts a request, drops finish, counts four cycles and returns the block.
module tb_data_cache;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [15:0] cpu_address = '0;
    logic [15:0] cpu_write_data = '0;
    logic [15:0] cpu_read_data;
    logic        cpu_ready;
    logic        readM;
    logic [15:0] address;
    logic [76:0] evict;
    logic [63:0] data;
    logic        finish;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    data_cache dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cpu_read       (cpu_read),
        .cpu_write      (cpu_write),
        .cpu_address    (cpu_address),
        .cpu_write_data (cpu_write_data),
        .cpu_read_data  (cpu_read_data),
        .cpu_ready      (cpu_ready),
        .readM          (readM),
        .address        (address),
        .evict          (evict),
        .data           (data),
        .finish         (finish),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [15:0] mem [256];
    logic [1:0]  m_state;
    int          m_cnt;
    int          txn_count = 0;
    logic [76:0] last_evict = '0;

    function automatic logic [63:0] mem_block(input logic [15:0] a);
        logic [63:0] blk;
        for (int k = 0; k < 4; k++) begin
            blk[k*16 +: 16] = mem[{a[7:2], 2'(k)}];
        end
        return blk;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state <= 2'd0;
            m_cnt   <= 0;
            finish  <= 1'b1;
            data    <= '0;
        end else begin
            case (m_state)
                2'd0: begin
                    if (readM && finish) begin
                        m_state    <= 2'd1;
                        txn_count  <= txn_count + 1;
                        last_evict <= evict;
                        if (evict[65]) begin
                            for (int k = 0; k < 4; k++) begin
                                mem[{evict[68:66], address[4:2], 2'(k)}] <= evict[k*16 +: 16];
                            end
                        end
                    end
                end
                2'd1: begin
                    finish  <= 1'b0;
                    m_cnt   <= 0;
                    m_state <= 2'd2;
                end
                default: begin
                    if (m_cnt == 3) begin
                        finish  <= 1'b1;
                        data    <= mem_block(address);
                        m_state <= 2'd0;
                    end else begin
                        m_cnt <= m_cnt + 1;
                    end
                end
            endcase
        end
    end

    // readM activity monitor: rising edges and readM still high when finish rises.
    int   readm_rises = 0;
    int   readm_viol  = 0;
    logic readm_d  = 1'b0;
    logic finish_d = 1'b1;
    always @(negedge clk) begin
        if (readM && !readm_d) readm_rises <= readm_rises + 1;
        if (finish && !finish_d && readM) readm_viol <= readm_viol + 1;
        readm_d  <= readM;
        finish_d <= finish;
    end

    // One CPU access: hold the request until cpu_ready (bounded), count edges
    // from the sampling edge (sampling edge counts as 1).
    task automatic do_access(input logic rd, input logic wr, input logic [15:0] a,
                             input logic [15:0] wd, output logic [15:0] rdata,
                             output int lat);
        @(negedge clk);
        cpu_read       = rd;
        cpu_write      = wr;
        cpu_address    = a;
        cpu_write_data = wd;
        lat   = 0;
        rdata = 16'hxxxx;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat = i + 1;
            if (cpu_ready) begin
                rdata = cpu_read_data;
                break;
            end
        end
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        $display("access rd=%0b wr=%0b addr=%h wdata=%h -> edges=%0d rdata=%h hits=%0d misses=%0d",
                 rd, wr, a, wd, lat, rdata, hit_count, miss_count);
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", cpu_ready); end
        n_checks++; if (readM !== 1'b0) begin n_fail++; $display("FAIL reset_readM: got %b want 0", readM); end
        n_checks++; if (evict !== 77'd0) begin n_fail++; $display("FAIL reset_evict: got %h want 0", evict); end
        n_checks++; if (cpu_read_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h want 0000", cpu_read_data); end
        n_checks++; if (hit_count !== 16'd0) begin n_fail++; $display("FAIL reset_hits: got %0d want 0", hit_count); end
        n_checks++; if (miss_count !== 16'd0) begin n_fail++; $display("FAIL reset_misses: got %0d want 0", miss_count); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (cpu_ready !== 1'b0 || readM !== 1'b0) begin n_fail++; $display("FAIL reset_release: ready=%b readM=%b want 0 0", cpu_ready, readM); end
        $display("reset checked");
    endtask

    task automatic test_cold_read();
        logic [15:0] rd; int lat; int t0; int r0;
        t0 = txn_count; r0 = readm_rises;
        do_access(1'b1, 1'b0, 16'h0001, 16'h0000, rd, lat);
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL cold_latency: got %0d want 8", lat); end
        n_checks++; if (rd !== 16'h0001) begin n_fail++; $display("FAIL cold_data: got %h want 0001", rd); end
        n_checks++; if (miss_count !== 16'd1) begin n_fail++; $display("FAIL cold_misses: got %0d want 1", miss_count); end
        n_checks++; if (last_evict[64] !== 1'b0 || last_evict[65] !== 1'b0) begin n_fail++; $display("FAIL cold_victim: valid=%b dirty=%b want 0 0", last_evict[64], last_evict[65]); end
        @(negedge clk);
        n_checks++; if (txn_count - t0 !== 1) begin n_fail++; $display("FAIL cold_txns: got %0d want 1", txn_count - t0); end
        n_checks++; if (readm_rises - r0 !== 1) begin n_fail++; $display("FAIL cold_readM_pulses: got %0d want 1", readm_rises - r0); end
        @(posedge clk); #1;
        n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL cold_ready_pulse: got %b want 0", cpu_ready); end
    endtask

    task automatic test_spatial_hit();
        logic [15:0] rd; int lat; int t0; int r0;
        t0 = txn_count; r0 = readm_rises;
        do_access(1'b1, 1'b0, 16'h0002, 16'h0000, rd, lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL hit_latency: got %0d want 1", lat); end
        n_checks++; if (rd !== 16'hFFFF) begin n_fail++; $display("FAIL hit_data: got %h want ffff", rd); end
        n_checks++; if (hit_count !== 16'd1) begin n_fail++; $display("FAIL hit_count: got %0d want 1", hit_count); end
        @(negedge clk);
        n_checks++; if (readm_rises - r0 !== 0 || txn_count - t0 !== 0) begin n_fail++; $display("FAIL hit_no_fetch: readM pulses %0d txns %0d want 0 0", readm_rises - r0, txn_count - t0); end
    endtask

    task automatic test_dirty_evict();
        logic [15:0] rd; int lat;
        do_access(1'b0, 1'b1, 16'h0003, 16'hBEEF, rd, lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL store_hit_latency: got %0d want 1", lat); end
        n_checks++; if (hit_count !== 16'd2) begin n_fail++; $display("FAIL store_hit_count: got %0d want 2", hit_count); end
        do_access(1'b1, 1'b0, 16'h0023, 16'h0000, rd, lat);
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL evict_latency: got %0d want 8", lat); end
        n_checks++; if (rd !== 16'h6000) begin n_fail++; $display("FAIL evict_read_data: got %h want 6000", rd); end
        n_checks++; if (last_evict[76:66] !== 11'd0) begin n_fail++; $display("FAIL evict_tag: got %h want 000", last_evict[76:66]); end
        n_checks++; if (last_evict[65] !== 1'b1 || last_evict[64] !== 1'b1) begin n_fail++; $display("FAIL evict_flags: dirty=%b valid=%b want 1 1", last_evict[65], last_evict[64]); end
        n_checks++; if (last_evict[63:48] !== 16'hBEEF) begin n_fail++; $display("FAIL evict_word3: got %h want beef", last_evict[63:48]); end
        n_checks++; if (miss_count !== 16'd2) begin n_fail++; $display("FAIL evict_misses: got %0d want 2", miss_count); end
        do_access(1'b1, 1'b0, 16'h0003, 16'h0000, rd, lat);
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL reread_latency: got %0d want 8", lat); end
        n_checks++; if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL reread_data: got %h want beef", rd); end
        n_checks++; if (last_evict[65] !== 1'b0 || last_evict[76:66] !== 11'd1) begin n_fail++; $display("FAIL reread_victim: dirty=%b tag=%h want 0 001", last_evict[65], last_evict[76:66]); end
        n_checks++; if (miss_count !== 16'd3) begin n_fail++; $display("FAIL reread_misses: got %0d want 3", miss_count); end
    endtask

    task automatic test_collision();
        logic [15:0] rd; int lat;
        do_access(1'b1, 1'b1, 16'h0005, 16'h1234, rd, lat);
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL collide_latency: got %0d want 8", lat); end
        n_checks++; if (miss_count !== 16'd4) begin n_fail++; $display("FAIL collide_misses: got %0d want 4", miss_count); end
        do_access(1'b1, 1'b0, 16'h0005, 16'h0000, rd, lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL collide_hit_latency: got %0d want 1", lat); end
        n_checks++; if (rd !== 16'h1234) begin n_fail++; $display("FAIL collide_read: got %h want 1234", rd); end
        n_checks++; if (hit_count !== 16'd3) begin n_fail++; $display("FAIL collide_hits: got %0d want 3", hit_count); end
    endtask

    task automatic test_back_to_back();
        int t0;
        t0 = txn_count;
        @(negedge clk);
        cpu_read = 1'b1; cpu_write = 1'b0; cpu_address = 16'h0004;
        @(posedge clk); #1;
        n_checks++; if (cpu_ready !== 1'b1 || cpu_read_data !== 16'hA004) begin n_fail++; $display("FAIL b2b_first: ready=%b data=%h want 1 a004", cpu_ready, cpu_read_data); end
        @(posedge clk); #1;
        n_checks++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_second: ready=%b want 1", cpu_ready); end
        cpu_read = 1'b0;
        n_checks++; if (hit_count !== 16'd5) begin n_fail++; $display("FAIL b2b_hits: got %0d want 5", hit_count); end
        @(posedge clk); #1;
        n_checks++; if (cpu_ready !== 1'b0 || txn_count != t0) begin n_fail++; $display("FAIL b2b_idle: ready=%b txns=%0d want 0 0", cpu_ready, txn_count - t0); end
        $display("back-to-back hits: hits=%0d", hit_count);
    endtask

    task automatic test_reset_mid_miss();
        logic [15:0] rd; int lat; int seen_ready;
        @(negedge clk);
        cpu_read = 1'b1; cpu_address = 16'h0041;
        repeat (5) @(posedge clk);
        #2;
        n_checks++; if (readM !== 1'b1) begin n_fail++; $display("FAIL midmiss_busy: readM=%b want 1", readM); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (readM !== 1'b0 || cpu_ready !== 1'b0) begin n_fail++; $display("FAIL midmiss_abort: readM=%b ready=%b want 0 0", readM, cpu_ready); end
        n_checks++; if (miss_count !== 16'd0 || hit_count !== 16'd0) begin n_fail++; $display("FAIL midmiss_counts: miss=%0d hit=%0d want 0 0", miss_count, hit_count); end
        cpu_read = 1'b0;
        seen_ready = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (cpu_ready) seen_ready++;
        end
        n_checks++; if (seen_ready !== 0) begin n_fail++; $display("FAIL midmiss_no_ready: got %0d pulses want 0", seen_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        $display("reset applied during WAIT");
        do_access(1'b1, 1'b0, 16'h0001, 16'h0000, rd, lat);
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL after_reset_latency: got %0d want 8", lat); end
        n_checks++; if (rd !== 16'h0001) begin n_fail++; $display("FAIL after_reset_data: got %h want 0001", rd); end
        n_checks++; if (miss_count !== 16'd1 || hit_count !== 16'd0) begin n_fail++; $display("FAIL after_reset_counts: miss=%0d hit=%0d want 1 0", miss_count, hit_count); end
        n_checks++; if (readm_viol !== 0) begin n_fail++; $display("FAIL readM_finish_overlap: got %0d want 0", readm_viol); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'hA000 | 16'(i);
        end
        mem[8'h01] = 16'h0001;
        mem[8'h02] = 16'hFFFF;
        mem[8'h23] = 16'h6000;

        test_reset();
        test_cold_read();
        test_spatial_hit();
        test_dirty_evict();
        test_collision();
        test_back_to_back();
        test_reset_mid_miss();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
